// File: rtl/spram_rr_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of one single-port RAM,
// with lock support and read-return routing. Define SPRAM_ARB_STATS_EN for grant/conflict counters.
module spram_rr_arbiter #(
  parameter  int DATA_WIDTH = 8,
  parameter  int ADDR_WIDTH = 8,
  parameter  int RD_LATENCY = 1,
  localparam int BV_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic                  a_we_i,
  input  logic                  a_lock_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic [BV_WIDTH-1:0]   a_byte_valid_i,
  output logic [DATA_WIDTH-1:0] a_rd_data_o,
  output logic                  a_rd_valid_o,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  input  logic                  b_we_i,
  input  logic                  b_lock_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  input  logic [BV_WIDTH-1:0]   b_byte_valid_i,
  output logic [DATA_WIDTH-1:0] b_rd_data_o,
  output logic                  b_rd_valid_o,
  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic [BV_WIDTH-1:0]   ram_byte_valid_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i
`ifdef SPRAM_ARB_STATS_EN
  ,
  output logic [15:0]           a_grant_cnt_o,
  output logic [15:0]           b_grant_cnt_o,
  output logic [15:0]           conflict_cnt_o
`endif
);

  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
    $fatal(1, "spram_rr_arbiter: RD_LATENCY must be 1 or 2");
  end

  localparam int TAP = RD_LATENCY - 1;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_prio;  // 0: A wins the next tie, 1: B wins it
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic [RD_LATENCY-1:0] r_sr_vld, r_sr_own;

  logic                  w_a_grant, w_b_grant, w_fire, w_sel_b, w_lock, w_we;
  logic [ADDR_WIDTH-1:0] w_addr;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missed branch would otherwise infer a latch.
  always_comb begin
    w_a_grant   = 1'b0;
    w_b_grant   = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ST_OWN_A: w_a_grant = a_valid_i;
      ST_OWN_B: w_b_grant = b_valid_i;
      default: begin
        w_a_grant = a_valid_i & (~b_valid_i | ~r_prio);
        w_b_grant = b_valid_i & (~a_valid_i |  r_prio);
      end
    endcase
    w_fire  = w_a_grant | w_b_grant;
    w_sel_b = w_b_grant;
    w_lock  = w_sel_b ? b_lock_i : a_lock_i;
    w_we    = w_sel_b ? b_we_i   : a_we_i;
    w_addr  = w_sel_b ? b_addr_i : a_addr_i;
    if (w_fire) begin
      if ((r_state == ST_ARB) && w_lock)
        w_state_nxt = w_sel_b ? ST_OWN_B : ST_OWN_A;
      else if ((r_state != ST_ARB) && !w_lock)
        w_state_nxt = ST_ARB;
    end
  end

  assign a_ready_o        = w_a_grant;
  assign b_ready_o        = w_b_grant;
  assign ram_wr_en_o      = w_fire & w_we;
  assign ram_addr_o       = w_fire ? w_addr : r_last_addr;
  assign ram_data_o       = w_sel_b ? b_data_i : a_data_i;
  assign ram_byte_valid_o = w_fire ? (w_sel_b ? b_byte_valid_i : a_byte_valid_i) : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_ARB;
      r_prio      <= 1'b0;
      r_last_addr <= '0;
      r_sr_vld    <= '0;
      r_sr_own    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) begin
        r_prio      <= ~w_sel_b;
        r_last_addr <= w_addr;
      end
      // Stage 0 is loaded on the fire edge, so the tap lines up with RAM data.
      r_sr_vld[0] <= w_fire & ~w_we;
      r_sr_own[0] <= w_sel_b;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_sr_vld[i] <= r_sr_vld[i-1];
        r_sr_own[i] <= r_sr_own[i-1];
      end
    end
  end

  assign a_rd_data_o  = ram_data_i;
  assign b_rd_data_o  = ram_data_i;
  assign a_rd_valid_o = r_sr_vld[TAP] & ~r_sr_own[TAP];
  assign b_rd_valid_o = r_sr_vld[TAP] &  r_sr_own[TAP];

`ifdef SPRAM_ARB_STATS_EN
  logic [15:0] r_a_cnt, r_b_cnt, r_conf_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_a_cnt    <= '0;
      r_b_cnt    <= '0;
      r_conf_cnt <= '0;
    end else begin
      if (w_a_grant && (r_a_cnt != 16'hFFFF)) r_a_cnt <= r_a_cnt + 16'd1;
      if (w_b_grant && (r_b_cnt != 16'hFFFF)) r_b_cnt <= r_b_cnt + 16'd1;
      if (a_valid_i && b_valid_i && w_fire && (r_conf_cnt != 16'hFFFF))
        r_conf_cnt <= r_conf_cnt + 16'd1;
    end
  end

  assign a_grant_cnt_o  = r_a_cnt;
  assign b_grant_cnt_o  = r_b_cnt;
  assign conflict_cnt_o = r_conf_cnt;
`endif

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Bench for spram_rr_arbiter: instance 0 is 8-bit/RD_LATENCY=1, instance 1 is 16-bit/RD_LATENCY=2.
// Directed tables plus random traffic checked against a transaction-level model.
module tb_spram_rr_arbiter;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic        lock;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [1:0]  bv;
  } req_t;

  typedef struct {
    int          g;
    int          due;
    bit          own_b;
    logic [15:0] data;
  } rd_exp_t;

  typedef struct {
    bit av, bv, al, bl, exp_ar, exp_br;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, s_rst_n;
  req_t in_a [2], in_b [2], s_a [2], s_b [2];

  wire [1:0]  o_a_ready, o_b_ready, o_a_rv, o_b_rv, o_ram_we;
  wire [15:0] o_a_rd [2], o_b_rd [2], o_ram_wd [2];
  wire [7:0]  o_ram_addr [2];
  wire [1:0]  o_ram_bv [2];
`ifdef SPRAM_ARB_STATS_EN
  wire [15:0] o_a_cnt [2], o_b_cnt [2], o_c_cnt [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int DW  = (g == 0) ? 8 : 16;
    localparam int LAT = (g == 0) ? 1 : 2;
    localparam int NB  = DW / 8;
    logic [DW-1:0] a_rd, b_rd, ram_wd, ram_q, q1, q2;
    logic [DW-1:0] mem [256];
    logic [7:0]    ram_addr;
    logic [NB-1:0] ram_bv;
    logic          ram_we, a_rdy, b_rdy, a_rv, b_rv;
`ifdef SPRAM_ARB_STATS_EN
    logic [15:0]   a_cnt, b_cnt, c_cnt;
`endif

    spram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(8), .RD_LATENCY(LAT)) u_dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .a_valid_i(in_a[g].valid), .a_ready_o(a_rdy), .a_we_i(in_a[g].we),
      .a_lock_i(in_a[g].lock), .a_addr_i(in_a[g].addr), .a_data_i(in_a[g].data[DW-1:0]),
      .a_byte_valid_i(in_a[g].bv[NB-1:0]), .a_rd_data_o(a_rd), .a_rd_valid_o(a_rv),
      .b_valid_i(in_b[g].valid), .b_ready_o(b_rdy), .b_we_i(in_b[g].we),
      .b_lock_i(in_b[g].lock), .b_addr_i(in_b[g].addr), .b_data_i(in_b[g].data[DW-1:0]),
      .b_byte_valid_i(in_b[g].bv[NB-1:0]), .b_rd_data_o(b_rd), .b_rd_valid_o(b_rv),
      .ram_wr_en_o(ram_we), .ram_addr_o(ram_addr), .ram_data_o(ram_wd),
      .ram_byte_valid_o(ram_bv), .ram_data_i(ram_q)
`ifdef SPRAM_ARB_STATS_EN
      , .a_grant_cnt_o(a_cnt), .b_grant_cnt_o(b_cnt), .conflict_cnt_o(c_cnt)
`endif
    );

    // Byte-masked single-port RAM; optional output register for LAT == 2.
    always @(posedge clk) begin
      if (ram_we)
        for (int k = 0; k < NB; k++)
          if (ram_bv[k]) mem[ram_addr][k*8 +: 8] <= ram_wd[k*8 +: 8];
      q1 <= mem[ram_addr];
      q2 <= q1;
    end
    assign ram_q = (LAT == 1) ? q1 : q2;

    assign o_a_ready[g]  = a_rdy;
    assign o_b_ready[g]  = b_rdy;
    assign o_a_rv[g]     = a_rv;
    assign o_b_rv[g]     = b_rv;
    assign o_ram_we[g]   = ram_we;
    assign o_a_rd[g]     = 16'(a_rd);
    assign o_b_rd[g]     = 16'(b_rd);
    assign o_ram_wd[g]   = 16'(ram_wd);
    assign o_ram_addr[g] = ram_addr;
    assign o_ram_bv[g]   = 2'(ram_bv);
`ifdef SPRAM_ARB_STATS_EN
    assign o_a_cnt[g] = a_cnt;
    assign o_b_cnt[g] = b_cnt;
    assign o_c_cnt[g] = c_cnt;
`endif
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: owner (0 none, 1 A, 2 B), tie-break winner, memory image, pending returns.
  int          mdl_own [2];
  bit          mdl_prio_b [2];
  logic [7:0]  mdl_last [2];
  logic [15:0] mdl_mem [2][256];
  rd_exp_t     exp_q [$];
`ifdef SPRAM_ARB_STATS_EN
  logic [15:0] m_acnt [2], m_bcnt [2], m_ccnt [2];
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mdl_reset();
    for (int g = 0; g < 2; g++) begin
      mdl_own[g]    = 0;
      mdl_prio_b[g] = 1'b0;
      mdl_last[g]   = '0;
`ifdef SPRAM_ARB_STATS_EN
      m_acnt[g] = '0; m_bcnt[g] = '0; m_ccnt[g] = '0;
`endif
    end
    exp_q.delete();
  endtask

  task automatic check_and_update(input int g);
    bit          ga, gb, fire, ea, eb;
    int          lat;
    logic [15:0] dmask, ed;
    logic [1:0]  bmask;
    req_t        r;
    lat   = (g == 0) ? 1 : 2;
    dmask = (g == 0) ? 16'h00FF : 16'hFFFF;
    bmask = (g == 0) ? 2'b01 : 2'b11;
    ga = 1'b0; gb = 1'b0;
    if (mdl_own[g] == 1)      ga = in_a[g].valid;
    else if (mdl_own[g] == 2) gb = in_b[g].valid;
    else if (in_a[g].valid && in_b[g].valid) begin
      ga = !mdl_prio_b[g]; gb = mdl_prio_b[g];
    end else begin
      ga = in_a[g].valid; gb = in_b[g].valid;
    end
    fire = ga | gb;
    r    = gb ? in_b[g] : in_a[g];

    check($sformatf("g%0d a_ready", g), o_a_ready[g], ga);
    check($sformatf("g%0d b_ready", g), o_b_ready[g], gb);
    check($sformatf("g%0d ram_wr_en", g), o_ram_we[g], fire & r.we);
    check($sformatf("g%0d ram_addr", g), o_ram_addr[g], fire ? r.addr : mdl_last[g]);
    check($sformatf("g%0d ram_bv", g), o_ram_bv[g], fire ? (r.bv & bmask) : 2'b00);
    if (fire && r.we) check($sformatf("g%0d ram_data", g), o_ram_wd[g], r.data & dmask);

    ea = 1'b0; eb = 1'b0; ed = '0;
    foreach (exp_q[i])
      if (exp_q[i].g == g && exp_q[i].due == cyc) begin
        if (exp_q[i].own_b) eb = 1'b1; else ea = 1'b1;
        ed = exp_q[i].data;
      end
    check($sformatf("g%0d a_rd_valid", g), o_a_rv[g], ea);
    check($sformatf("g%0d b_rd_valid", g), o_b_rv[g], eb);
    if (ea) check($sformatf("g%0d a_rd_data", g), o_a_rd[g], ed);
    if (eb) check($sformatf("g%0d b_rd_data", g), o_b_rd[g], ed);
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].g == g && exp_q[i].due <= cyc) exp_q.delete(i);

`ifdef SPRAM_ARB_STATS_EN
    check($sformatf("g%0d a_grant_cnt", g), o_a_cnt[g], m_acnt[g]);
    check($sformatf("g%0d b_grant_cnt", g), o_b_cnt[g], m_bcnt[g]);
    check($sformatf("g%0d conflict_cnt", g), o_c_cnt[g], m_ccnt[g]);
`endif

    if (!rst_n) return;
    if (fire) begin
      mdl_last[g] = r.addr;
      if (r.we) begin
        for (int k = 0; k < 2; k++)
          if (bmask[k] && r.bv[k]) mdl_mem[g][r.addr][k*8 +: 8] = r.data[k*8 +: 8];
      end else begin
        exp_q.push_back('{g, cyc + lat, gb, mdl_mem[g][r.addr]});
      end
      mdl_prio_b[g] = !gb;
      if (mdl_own[g] == 0 && r.lock)       mdl_own[g] = gb ? 2 : 1;
      else if (mdl_own[g] != 0 && !r.lock) mdl_own[g] = 0;
    end
`ifdef SPRAM_ARB_STATS_EN
    if (ga && m_acnt[g] != 16'hFFFF) m_acnt[g]++;
    if (gb && m_bcnt[g] != 16'hFFFF) m_bcnt[g]++;
    if (in_a[g].valid && in_b[g].valid && fire && m_ccnt[g] != 16'hFFFF) m_ccnt[g]++;
`endif
  endtask

  // One bus cycle: inputs change on the falling edge, outputs are checked 2 ns later.
  task automatic tick();
    @(negedge clk);
    rst_n = s_rst_n;
    in_a  = s_a;
    in_b  = s_b;
    if (!s_rst_n) mdl_reset();
    #2;
    cyc++;
    for (int g = 0; g < 2; g++) check_and_update(g);
  endtask

  task automatic set_idle();
    for (int g = 0; g < 2; g++) begin
      s_a[g] = '0;
      s_b[g] = '0;
    end
  endtask

  function automatic req_t mk(input bit v, input bit we, input bit lk,
                              input logic [7:0] ad, input logic [15:0] d, input logic [1:0] bv);
    req_t r;
    r.valid = v; r.we = we; r.lock = lk; r.addr = ad; r.data = d; r.bv = bv;
    return r;
  endfunction

  vec_t vecs [13];

  initial begin
    for (int g = 0; g < 2; g++)
      for (int a = 0; a < 256; a++) mdl_mem[g][a] = '0;
    set_idle();
    in_a = s_a;
    in_b = s_b;
    rst_n   = 1'b1;
    s_rst_n = 1'b0;
    mdl_reset();
    #1 rst_n = 1'b0;
    tick(); tick();
    s_rst_n = 1'b1;
    tick();

    // Round-robin alternation, then A locks, idles three cycles and unlocks.
    vecs[0]  = '{1, 1, 0, 0, 1, 0};
    vecs[1]  = '{1, 1, 0, 0, 0, 1};
    vecs[2]  = '{1, 1, 0, 0, 1, 0};
    vecs[3]  = '{1, 1, 0, 0, 0, 1};
    vecs[4]  = '{1, 1, 0, 0, 1, 0};
    vecs[5]  = '{1, 1, 0, 0, 0, 1};
    vecs[6]  = '{1, 1, 1, 0, 1, 0};
    vecs[7]  = '{0, 1, 0, 0, 0, 0};
    vecs[8]  = '{0, 1, 0, 0, 0, 0};
    vecs[9]  = '{0, 1, 0, 0, 0, 0};
    vecs[10] = '{1, 1, 0, 0, 1, 0};
    vecs[11] = '{1, 1, 0, 0, 0, 1};
    vecs[12] = '{0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 13; i++) begin
      set_idle();
      s_a[0] = mk(vecs[i].av, 1'b1, vecs[i].al, 8'(8'h20 + i), 16'($urandom), 2'b01);
      s_b[0] = mk(vecs[i].bv, 1'b1, vecs[i].bl, 8'(8'h40 + i), 16'($urandom), 2'b01);
      tick();
      check($sformatf("vec%0d a_ready", i), o_a_ready[0], vecs[i].exp_ar);
      check($sformatf("vec%0d b_ready", i), o_b_ready[0], vecs[i].exp_br);
`ifdef SPRAM_ARB_STATS_EN
      if (i == 6) begin
        check("stats a_grant_cnt", o_a_cnt[0], 16'd3);
        check("stats b_grant_cnt", o_b_cnt[0], 16'd3);
        check("stats conflict_cnt", o_c_cnt[0], 16'd6);
      end
`endif
    end

    // Write then read back on the 8-bit, latency-1 instance.
    set_idle();
    s_a[0] = mk(1, 1, 0, 8'h10, 16'h00A5, 2'b01);
    tick();
    s_a[0] = mk(1, 0, 0, 8'h10, 16'h0000, 2'b00);
    tick();
    set_idle();
    tick();
    check("wr_rd a_rd_valid", o_a_rv[0], 1'b1);
    check("wr_rd a_rd_data", o_a_rd[0], 16'h00A5);
    check("wr_rd b_rd_valid", o_b_rv[0], 1'b0);

    // Byte-masked merge on the 16-bit, latency-2 instance.
    s_b[1] = mk(1, 1, 0, 8'h03, 16'h1234, 2'b11);
    tick();
    set_idle();
    s_a[1] = mk(1, 1, 0, 8'h03, 16'hFF00, 2'b10);
    tick();
    set_idle();
    s_b[1] = mk(1, 0, 0, 8'h03, 16'h0000, 2'b00);
    tick();
    set_idle();
    tick();
    check("merge b_rd_valid early", o_b_rv[1], 1'b0);
    tick();
    check("merge b_rd_valid", o_b_rv[1], 1'b1);
    check("merge b_rd_data", o_b_rd[1], 16'hFF34);

    // Reads in flight when reset hits are dropped; priority returns to A.
    s_a[0] = mk(1, 0, 0, 8'h10, 16'h0000, 2'b00);
    s_a[1] = mk(1, 0, 0, 8'h03, 16'h0000, 2'b00);
    tick();
    set_idle();
    tick();
    #1 rst_n = 1'b0;
    s_rst_n = 1'b0;
    mdl_reset();
    tick();
    check("reset g1 b_rd_valid", o_b_rv[1], 1'b0);
    check("reset g1 a_rd_valid", o_a_rv[1], 1'b0);
    tick();
    s_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post-reset g1 a_rd_valid", o_a_rv[1], 1'b0);
    end
    for (int g = 0; g < 2; g++) begin
      s_a[g] = mk(1, 1, 0, 8'h30, 16'h5A5A, 2'b11);
      s_b[g] = mk(1, 1, 0, 8'h31, 16'hA5A5, 2'b11);
    end
    tick();
    check("post-reset dual g0 a_ready", o_a_ready[0], 1'b1);
    check("post-reset dual g0 b_ready", o_b_ready[0], 1'b0);
    check("post-reset dual g1 a_ready", o_a_ready[1], 1'b1);
    check("post-reset dual g1 b_ready", o_b_ready[1], 1'b0);

    // Preload the random address window so every read returns defined data.
    for (int a = 0; a < 16; a++) begin
      set_idle();
      for (int g = 0; g < 2; g++) s_a[g] = mk(1, 1, 0, 8'(a), 16'($urandom), 2'b11);
      tick();
    end

    for (int n = 0; n < 600; n++) begin
      for (int g = 0; g < 2; g++) begin
        s_a[g] = mk($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
                    8'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)));
        s_b[g] = mk($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
                    8'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)));
      end
      tick();
    end
    set_idle();
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
